// File: rtl/filtros_seq_ctrl.sv
// Sequencer for the 27-lane filter bank: streams a 16-sample window in, captures the
// bank results, then emits them as up / middle / down 9-lane beats, ROWS rows per block.
module filtros_seq_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 8,
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int SW        = DATA_WIDTH + 2,
   localparam int MW        = DATA_WIDTH + 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SW-1:0]       in_sample,
   output logic [16*SW-1:0]    win_bus,
   input  logic [9*SW-1:0]     up_bus,
   input  logic [9*MW-1:0]     mid_bus,
   input  logic [9*SW-1:0]     down_bus,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          out_sel,
   output logic [9*MW-1:0]     out_data,
   output logic [ROW_W-1:0]    out_row
);

   typedef enum logic [1:0] {IDLE, LOAD, CAPT, EMIT} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        scnt_reg, scnt_next;
   logic [ROW_W-1:0]  row_reg, row_next;
   logic [1:0]        sel_reg, sel_next;
   logic              done_reg, done_next;
   logic [9*SW-1:0]   up_reg, down_reg;
   logic [9*MW-1:0]   mid_reg;
   logic              wr_en, cap_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         scnt_reg  <= '0;
         row_reg   <= '0;
         sel_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         scnt_reg  <= scnt_next;
         row_reg   <= row_next;
         sel_reg   <= sel_next;
         done_reg  <= done_next;
      end
   end

   // abort overrides everything and also gates both handshakes for that cycle
   always_comb begin
      state_next = state_reg;
      scnt_next  = scnt_reg;
      row_next   = row_reg;
      sel_next   = sel_reg;
      done_next  = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      if (abort) begin
         state_next = IDLE;
         scnt_next  = '0;
         row_next   = '0;
         sel_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_next = LOAD;
                  scnt_next  = '0;
                  row_next   = '0;
                  sel_next   = '0;
               end
            end
            LOAD: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  scnt_next = scnt_reg + 4'd1;
                  if (scnt_reg == 4'd15)
                     state_next = CAPT;
               end
            end
            CAPT: begin
               state_next = EMIT;
               sel_next   = '0;
            end
            EMIT: begin
               out_valid = 1'b1;
               if (out_ready) begin
                  if (sel_reg == 2'd2) begin
                     sel_next  = '0;
                     scnt_next = '0;
                     if (row_reg == ROW_W'(ROWS - 1)) begin
                        state_next = IDLE;
                        row_next   = '0;
                        done_next  = 1'b1;
                     end else begin
                        state_next = LOAD;
                        row_next   = ROW_W'(row_reg + 1'b1);
                     end
                  end else begin
                     sel_next = sel_reg + 2'd1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign wr_en  = in_ready & in_valid;
   assign cap_en = (state_reg == CAPT) & ~abort;

   // window slots persist across rows; each is overwritten only by its own accept
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_win
         logic [SW-1:0] slot_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               slot_reg <= '0;
            else if (wr_en && scnt_reg == 4'(gi))
               slot_reg <= in_sample;
         end
         assign win_bus[gi*SW +: SW] = slot_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_reg   <= '0;
         mid_reg  <= '0;
         down_reg <= '0;
      end else if (cap_en) begin
         up_reg   <= up_bus;
         mid_reg  <= mid_bus;
         down_reg <= down_bus;
      end
   end

   generate
      for (gi = 0; gi < 9; gi++) begin : g_lane
         logic [MW-1:0] up_ext, dn_ext;
         assign up_ext = {up_reg[gi*SW + SW - 1], up_reg[gi*SW +: SW]};
         assign dn_ext = {down_reg[gi*SW + SW - 1], down_reg[gi*SW +: SW]};
         assign out_data[gi*MW +: MW] = (sel_reg == 2'd0) ? up_ext :
                                        (sel_reg == 2'd1) ? mid_reg[gi*MW +: MW] :
                                        (sel_reg == 2'd2) ? dn_ext : '0;
      end
   endgenerate

   assign busy    = (state_reg != IDLE);
   assign done    = done_reg;
   assign out_sel = sel_reg;
   assign out_row = row_reg;

endmodule

// File: tb/tb_filtros_seq_ctrl.sv
// Scoreboard bench for filtros_seq_ctrl (DATA_WIDTH=8, ROWS=2) with a constant bank stub.
module tb_filtros_seq_ctrl;
   localparam int DW = 8, ROWS = 2, SW = 10, MW = 11, RW = 1;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [SW-1:0] in_sample = '0;
   logic busy, done, in_ready, out_valid;
   logic [16*SW-1:0] win_bus;
   logic [9*SW-1:0] up_bus, down_bus;
   logic [9*MW-1:0] mid_bus, out_data;
   logic [1:0] out_sel;
   logic [RW-1:0] out_row;

   filtros_seq_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .win_bus(win_bus),
      .up_bus(up_bus), .mid_bus(mid_bus), .down_bus(down_bus), .out_valid(out_valid),
      .out_ready(out_ready), .out_sel(out_sel), .out_data(out_data), .out_row(out_row));

   always #5 clk = ~clk;

   // bank stub: up lane i = -i, mid lane i = 100+i, down lane i = -50-i
   always_comb begin
      up_bus = '0; mid_bus = '0; down_bus = '0;
      for (int i = 0; i < 9; i++) begin
         up_bus[i*SW +: SW]   = SW'(-i);
         mid_bus[i*MW +: MW]  = MW'(100 + i);
         down_bus[i*SW +: SW] = SW'(-50 - i);
      end
   end

   typedef struct packed {
      logic [1:0]      sel;
      logic [RW-1:0]   row;
      logic [9*MW-1:0] data;
   } beat_t;
   beat_t sb[$];

   int n_cmp = 0, n_err = 0;
   int cyc = 0, hs_cnt = 0, hs_cyc = -10, done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [9*MW-1:0] exp_data(int sel);
      logic [9*MW-1:0] d;
      int v;
      d = '0;
      for (int i = 0; i < 9; i++) begin
         v = (sel == 0) ? -i : (sel == 1) ? 100 + i : -50 - i;
         d[i*MW +: MW] = MW'(v);
      end
      return d;
   endfunction

   task automatic push_row(int r);
      for (int s = 0; s < 3; s++) sb.push_back({2'(s), RW'(r), exp_data(s)});
   endtask

   // monitor: pops the scoreboard on every output handshake
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            hs_cnt++;
            hs_cyc = cyc;
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL beat_unexpected: got sel=%0d row=%0d expected no beat", out_sel, out_row);
            end else begin
               e = sb.pop_front();
               check("beat_sel", out_sel, e.sel);
               check("beat_row", out_row, e.row);
               check("beat_data", out_data, e.data);
            end
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(int base, int n);
      int t;
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_sample = SW'(base + k);
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 200) begin @(negedge clk); t++; end
         if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL feed_timeout: got in_ready=0 expected 1 (sample %0d)", base + k);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while (!done && t < 300) begin @(negedge clk); t++; end
      check("done_seen", done, 1);
      check("done_latency", cyc - hs_cyc, 1);
      check("busy_at_done", busy, 0);
      @(posedge clk); #1;
   endtask

   logic [16*SW-1:0] exp_win;
   int d0, h0, seen;

   initial begin
      // reset state
      repeat (2) @(posedge clk); #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_win", win_bus, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sel", out_sel, 0);
      check("rst_out_row", out_row, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // window assembly and first-beat latency
      pulse_start();
      feed(0, 16);
      push_row(0);
      @(negedge clk);
      check("capt_no_valid", out_valid, 0);
      @(negedge clk);
      check("emit_valid", out_valid, 1);
      for (int k = 0; k < 16; k++) exp_win[k*SW +: SW] = SW'(k);
      check("win_0_15", win_bus, exp_win);
      check("first_sel", out_sel, 0);
      check("up_lane3", out_data[3*MW +: MW], 11'h7FD);
      check("first_row", out_row, 0);

      // backpressure at sel=1
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_sel", out_sel, 1);
         check("hold_mid_lane0", out_data[0 +: MW], 11'd100);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rel_sel", out_sel, 2);
      check("down_lane8", out_data[8*MW +: MW], 11'h7C6);
      @(posedge clk); #1;

      // async reset in the middle of row 1
      feed(16, 5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_win", win_bus, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_sb_empty", sb.size(), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // full block, no backpressure
      out_ready = 1'b1;
      d0 = done_cnt; h0 = hs_cnt;
      pulse_start();
      feed(32, 16); push_row(0);
      feed(48, 16); push_row(1);
      wait_done();
      repeat (3) @(posedge clk); #1;
      check("blk_beats", hs_cnt - h0, 6);
      check("blk_sb_empty", sb.size(), 0);
      check("blk_one_done", done_cnt - d0, 1);

      // abort after 7 accepts, then restart
      d0 = done_cnt;
      pulse_start();
      feed(50, 7);
      abort = 1'b1;
      @(negedge clk);
      check("abort_gates_ready", in_ready, 0);
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      check("abort_idle", busy, 0);
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (out_valid || done) seen++;
      end
      check("abort_quiet", seen, 0);
      check("abort_no_done", done_cnt - d0, 0);
      @(posedge clk); #1;
      pulse_start();
      feed(200, 16);
      @(negedge clk);
      check("restart_slot0", win_bus[0 +: SW], 10'd200);
      check("restart_slot15", win_bus[15*SW +: SW], 10'd215);
      push_row(0);
      @(posedge clk); #1;
      feed(216, 16); push_row(1);
      wait_done();
      check("restart_one_done", done_cnt - d0, 1);

      // start pulses while busy must be ignored
      out_ready = 1'b0;
      d0 = done_cnt; h0 = hs_cnt;
      pulse_start();
      feed(100, 8);
      pulse_start();
      feed(108, 8); push_row(0);
      @(posedge clk); #1;
      check("emit_before_start", out_valid, 1);
      pulse_start();
      out_ready = 1'b1;
      feed(116, 16); push_row(1);
      wait_done();
      repeat (3) @(posedge clk); #1;
      check("busy_start_beats", hs_cnt - h0, 6);
      check("busy_start_one_done", done_cnt - d0, 1);
      check("busy_start_sb_empty", sb.size(), 0);
      check("final_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
